// File: rtl/cr_xp10_decomp_fe_crc_acc.sv
// Multi-channel CRC32C accumulator for the XP10 decompressor front end.
// Folds variable-size beats into a per-channel running CRC and emits a checked result at eof.
module cr_xp10_decomp_fe_crc_acc #(
    parameter int          DATA_W  = 64,
    parameter int          N_CH    = 4,
    parameter logic [31:0] POLY    = 32'h82f63b78,
    parameter logic [31:0] INIT    = 32'hffff_ffff,
    parameter logic [31:0] XOR_OUT = 32'hffff_ffff,
    localparam int         CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int         SZ_W    = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SZ_W-1:0]   in_sz,
    input  logic [31:0]       in_crc_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [31:0]       out_crc,
    output logic [1:0]        out_err
);

    localparam logic [SZ_W-1:0] SZ_MAX = SZ_W'(DATA_W);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid must not depend on ready, and an offered item is held stable until it transfers.

    logic [31:0]     crc_q [N_CH];
    logic [N_CH-1:0] active_q;
    logic [N_CH-1:0] ferr_q;

    logic            accept;
    logic            cur_active;
    logic            cur_ferr;
    logic            ferr_nxt;
    logic [SZ_W-1:0] sz_eff;
    logic [31:0]     seed;
    logic [31:0]     crc_nxt;
    logic [31:0]     crc_fin;

    // Bit-serial reflected CRC over the low sz bits (whole bytes only).
    function automatic logic [31:0] crc_fold(input logic [31:0]     seed_in,
                                             input logic [DATA_W-1:0] data,
                                             input logic [SZ_W-1:0]   sz);
        logic [31:0]     c;
        logic [SZ_W-1:0] nbits;
        c     = seed_in;
        nbits = {sz[SZ_W-1:3], 3'b000};
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(nbits)) begin
                c = {1'b0, c[31:1]} ^ ((c[0] ^ data[i]) ? POLY : 32'h0);
            end
        end
        return c;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cur_active = active_q[in_ch];
        cur_ferr   = ferr_q[in_ch];
        // A beat with no open frame (or a sof over an open one) restarts from INIT.
        seed       = (in_sof || !cur_active) ? INIT : crc_q[in_ch];
        ferr_nxt   = in_sof ? cur_active : (cur_ferr | ~cur_active);
        sz_eff     = (in_sz > SZ_MAX) ? SZ_MAX : in_sz;
        crc_nxt    = crc_fold(seed, in_data, sz_eff);
        crc_fin    = crc_nxt ^ XOR_OUT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                crc_q[c] <= INIT;
            end
            active_q <= '0;
            ferr_q   <= '0;
        end else if (accept) begin
            if (in_eof) begin
                crc_q[in_ch]    <= INIT;
                active_q[in_ch] <= 1'b0;
                ferr_q[in_ch]   <= 1'b0;
            end else begin
                crc_q[in_ch]    <= crc_nxt;
                active_q[in_ch] <= 1'b1;
                ferr_q[in_ch]   <= ferr_nxt;
            end
        end
    end

    // Single result register; a new eof can replace a result in the cycle it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_crc   <= '0;
            out_err   <= '0;
        end else if (accept && in_eof) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_crc   <= crc_fin;
            out_err   <= {ferr_nxt, (crc_fin != in_crc_exp)};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    a_sz_legal : assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready) |-> ((in_sz <= SZ_MAX) && (in_sz[2:0] == 3'b000)));

endmodule
